// File: rtl/mm_tile_feeder.sv
// Tile sequencer for mm_unit: walks the m/k/n tile loops, gathers A-row and B-column
// lines from two 1-cycle-latency read ports, and presents one registered tile per issue.
module mm_tile_feeder #(
  parameter int M      = 16,
  parameter int K      = 16,
  parameter int N      = 16,
  parameter int M_TILE = 4,
  parameter int K_TILE = 4,
  parameter int N_TILE = 4,
  parameter int DW_MUL = 8,
  parameter int DW_INT = 8,
  parameter int AW     = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              a_rd_en,
  output logic [AW-1:0]                     a_rd_addr,
  input  logic [DW_MUL*K_TILE-1:0]          a_rd_data,
  output logic                              b_rd_en,
  output logic [AW-1:0]                     b_rd_addr,
  input  logic [DW_MUL*K_TILE-1:0]          b_rd_data,
  output logic                              enable,
  output logic [1:0]                        in_valid,
  output logic [DW_INT-1:0]                 ptr_m,
  output logic [DW_INT-1:0]                 ptr_k,
  output logic [DW_INT-1:0]                 ptr_n,
  output logic [DW_MUL*K_TILE*M_TILE-1:0]   in_a,
  output logic [DW_MUL*K_TILE*N_TILE-1:0]   in_b
);

  localparam int LW    = DW_MUL * K_TILE;
  localparam int KT    = K / K_TILE;
  localparam int NUM_M = M / M_TILE;
  localparam int NUM_K = K / K_TILE;
  localparam int NUM_N = N / N_TILE;
  localparam int CMAX  = (M_TILE > N_TILE) ? M_TILE : N_TILE;
  localparam int CW    = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_ISSUE,
    ST_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [DW_INT-1:0]          tm_q, tm_d, tk_q, tk_d, tn_q, tn_d;
  logic [M_TILE-1:0][LW-1:0]  a_stage_q, a_stage_d;
  logic [N_TILE-1:0][LW-1:0]  b_stage_q, b_stage_d;
  logic                       issue_load;

  logic [1:0]                 in_valid_q;
  logic [DW_INT-1:0]          ptr_m_q, ptr_k_q, ptr_n_q;
  logic [M_TILE-1:0][LW-1:0]  in_a_q;
  logic [N_TILE-1:0][LW-1:0]  in_b_q;

  logic last_m, last_k, last_n;

  assign last_m = (tm_q == DW_INT'(NUM_M - 1));
  assign last_k = (tk_q == DW_INT'(NUM_K - 1));
  assign last_n = (tn_q == DW_INT'(NUM_N - 1));

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tm_d       = tm_q;
    tk_d       = tk_q;
    tn_d       = tn_q;
    a_stage_d  = a_stage_q;
    b_stage_d  = b_stage_q;
    issue_load = 1'b0;
    a_rd_en    = 1'b0;
    a_rd_addr  = '0;
    b_rd_en    = 1'b0;
    b_rd_addr  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD_A;
          cnt_d   = '0;
          tm_d    = '0;
          tk_d    = '0;
          tn_d    = '0;
        end
      end

      ST_LOAD_A: begin
        if (cnt_q < CW'(M_TILE)) begin
          a_rd_en   = 1'b1;
          a_rd_addr = AW'((int'(tm_q) * M_TILE + int'(cnt_q)) * KT + int'(tk_q));
        end
        // Read data lags the strobe by one cycle, so count c lands in row c-1.
        for (int r = 0; r < M_TILE; r++) begin
          if (cnt_q == CW'(r + 1)) a_stage_d[r] = a_rd_data;
        end
        if (cnt_q == CW'(M_TILE)) begin
          state_d = ST_LOAD_B;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_LOAD_B: begin
        if (cnt_q < CW'(N_TILE)) begin
          b_rd_en   = 1'b1;
          b_rd_addr = AW'((int'(tn_q) * N_TILE + int'(cnt_q)) * KT + int'(tk_q));
        end
        for (int r = 0; r < N_TILE; r++) begin
          if (cnt_q == CW'(r + 1)) b_stage_d[r] = b_rd_data;
        end
        if (cnt_q == CW'(N_TILE)) begin
          state_d    = ST_ISSUE;
          cnt_d      = '0;
          issue_load = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_ISSUE: begin
        cnt_d = '0;
        if (last_n) begin
          tn_d = '0;
          if (last_k) begin
            tk_d = '0;
            tm_d = last_m ? '0 : tm_q + 1'b1;
          end else begin
            tk_d = tk_q + 1'b1;
          end
        end else begin
          tn_d = tn_q + 1'b1;
        end
        // A new k or m index means a new A tile, which always starts at n == 0.
        if (last_n && last_k && last_m) state_d = ST_DONE;
        else if (last_n)                state_d = ST_LOAD_A;
        else                            state_d = ST_LOAD_B;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tm_q       <= '0;
      tk_q       <= '0;
      tn_q       <= '0;
      // NOTE: the staging and output tile registers are cleared too, so in_a/in_b read 0 after reset.
      a_stage_q  <= '0;
      b_stage_q  <= '0;
      in_valid_q <= 2'b00;
      ptr_m_q    <= '0;
      ptr_k_q    <= '0;
      ptr_n_q    <= '0;
      in_a_q     <= '0;
      in_b_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tm_q      <= tm_d;
      tk_q      <= tk_d;
      tn_q      <= tn_d;
      a_stage_q <= a_stage_d;
      b_stage_q <= b_stage_d;
      in_valid_q <= issue_load ? ((tn_q == '0) ? 2'b11 : 2'b01) : 2'b00;
      if (issue_load) begin
        // The last B column arrives on this same edge, hence the _d copy.
        in_a_q  <= a_stage_q;
        in_b_q  <= b_stage_d;
        ptr_m_q <= tm_q;
        ptr_k_q <= tk_q;
        ptr_n_q <= tn_q;
      end
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign enable   = busy;
  assign done     = (state_q == ST_DONE);
  assign in_valid = in_valid_q;
  assign ptr_m    = ptr_m_q;
  assign ptr_k    = ptr_k_q;
  assign ptr_n    = ptr_n_q;
  assign in_a     = in_a_q;
  assign in_b     = in_b_q;

endmodule
